// File: rtl/pipe_datapath.sv
// pipe_datapath: parametrised 5-stage (IF/ID/EX/MEM/WB) datapath with per-stage
// valid bits, EX operand forwarding, load-use stall/bubble and a retire counter.
// Control decode and both memories are external.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   imem_addr / imem_rdata   current PC / instruction at that PC (same cycle)
//   opcode                   IF/ID instr[15:12], decoded externally
//   alu_sel, reg_write_en,
//   mem_write_en, mem_to_reg,
//   mem_op                   control for the instruction in ID (same cycle)
//   dmem_addr/wdata/we       MEM-stage data memory access, write on clk edge
//   dmem_rdata               combinational read of dmem_addr
//   stall                    PC and IF/ID held this cycle (combinational)
//   retire_cnt               valid instructions that completed WB, wraps
module pipe_datapath #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [15:0]         imem_rdata,
  output logic [3:0]          opcode,
  input  logic [1:0]          alu_sel,
  input  logic                reg_write_en,
  input  logic                mem_write_en,
  input  logic                mem_to_reg,
  input  logic                mem_op,
  output logic [7:0]          dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic                dmem_we,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                stall,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_N   = 16;
  localparam int unsigned RIDX_W  = 4;
  localparam int unsigned MADDR_W = 8;
  localparam bit          FWD     = (FWD_EN != 0);

  // Pending-write match: a valid stage that will write rd, and rd is the source.
  function automatic logic hit(input logic v, input logic we,
                               input logic [RIDX_W-1:0] rd,
                               input logic [RIDX_W-1:0] src);
    return v && we && (rd == src);
  endfunction

  // Fetch / IF/ID
  logic [PC_W-1:0]    pc;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;

  // ID/EX
  logic               id_ex_valid;
  logic               id_ex_rwe;
  logic               id_ex_mwe;
  logic               id_ex_mtr;
  logic [1:0]         id_ex_alu_sel;
  logic [RIDX_W-1:0]  id_ex_rd;
  logic [RIDX_W-1:0]  id_ex_src1;
  logic [RIDX_W-1:0]  id_ex_src2;
  logic [DATA_W-1:0]  id_ex_op1;
  logic [DATA_W-1:0]  id_ex_op2;
  logic [MADDR_W-1:0] id_ex_addr;

  // EX/MEM
  logic               ex_mem_valid;
  logic               ex_mem_rwe;
  logic               ex_mem_mwe;
  logic               ex_mem_mtr;
  logic [RIDX_W-1:0]  ex_mem_rd;
  logic [DATA_W-1:0]  ex_mem_alu;
  logic [DATA_W-1:0]  ex_mem_sdata;
  logic [MADDR_W-1:0] ex_mem_addr;

  // MEM/WB
  logic               mem_wb_valid;
  logic               mem_wb_rwe;
  logic [RIDX_W-1:0]  mem_wb_rd;
  logic [DATA_W-1:0]  mem_wb_data;

  logic [DATA_W-1:0]  regfile [REG_N];

  // ID-stage combinational signals
  logic [RIDX_W-1:0]  id_rd;
  logic [RIDX_W-1:0]  id_rs2;
  logic [RIDX_W-1:0]  id_src1;
  logic               id_use1;
  logic               id_use2;
  logic [DATA_W-1:0]  id_rdata1;
  logic [DATA_W-1:0]  id_rdata2;
  logic               wb_write;
  logic               busy1;
  logic               busy2;
  logic               hazard;

  // EX-stage combinational signals
  logic [DATA_W-1:0]  ex_a;
  logic [DATA_W-1:0]  ex_b;
  logic [DATA_W-1:0]  ex_alu;

  assign imem_addr  = pc;
  assign opcode     = if_id_instr[15:12];
  assign dmem_addr  = ex_mem_addr;
  assign dmem_wdata = ex_mem_sdata;
  assign dmem_we    = !rst && ex_mem_valid && ex_mem_mwe;
  assign stall      = !rst && hazard;
  assign wb_write   = mem_wb_valid && mem_wb_rwe;

  // Decode register fields; a store reads rd as its data on read port 1.
  // Loads use no register source, so they never wait on a producer.
  always_comb begin
    id_rd   = if_id_instr[11:8];
    id_rs2  = if_id_instr[3:0];
    id_src1 = mem_write_en ? if_id_instr[11:8] : if_id_instr[7:4];
    id_use1 = (reg_write_en && !mem_op) || mem_write_en;
    id_use2 = reg_write_en && !mem_op;
  end

  // Register read with write-through from the instruction retiring this cycle.
  always_comb begin
    id_rdata1 = regfile[id_src1];
    id_rdata2 = regfile[id_rs2];
    if (wb_write && (mem_wb_rd == id_src1)) id_rdata1 = mem_wb_data;
    if (wb_write && (mem_wb_rd == id_rs2))  id_rdata2 = mem_wb_data;
  end

  // Hazard detection: with forwarding only a load in EX blocks a consumer;
  // without it, any in-flight write to a source blocks until it has retired.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (FWD) begin
      busy1 = hit(id_ex_valid, id_ex_rwe && id_ex_mtr, id_ex_rd, id_src1);
      busy2 = hit(id_ex_valid, id_ex_rwe && id_ex_mtr, id_ex_rd, id_rs2);
    end else begin
      busy1 = hit(id_ex_valid, id_ex_rwe, id_ex_rd, id_src1)
           || hit(ex_mem_valid, ex_mem_rwe, ex_mem_rd, id_src1)
           || hit(mem_wb_valid, mem_wb_rwe, mem_wb_rd, id_src1);
      busy2 = hit(id_ex_valid, id_ex_rwe, id_ex_rd, id_rs2)
           || hit(ex_mem_valid, ex_mem_rwe, ex_mem_rd, id_rs2)
           || hit(mem_wb_valid, mem_wb_rwe, mem_wb_rd, id_rs2);
    end
    hazard = if_id_valid && ((id_use1 && busy1) || (id_use2 && busy2));
  end

  // EX operand selection (EX/MEM beats MEM/WB beats ID/EX) and ALU.
  // A load in EX/MEM has no data yet, so it is excluded from that path.
  always_comb begin
    ex_a = id_ex_op1;
    ex_b = id_ex_op2;
    if (FWD) begin
      if (hit(ex_mem_valid, ex_mem_rwe && !ex_mem_mtr, ex_mem_rd, id_ex_src1))
        ex_a = ex_mem_alu;
      else if (hit(mem_wb_valid, mem_wb_rwe, mem_wb_rd, id_ex_src1))
        ex_a = mem_wb_data;
      if (hit(ex_mem_valid, ex_mem_rwe && !ex_mem_mtr, ex_mem_rd, id_ex_src2))
        ex_b = ex_mem_alu;
      else if (hit(mem_wb_valid, mem_wb_rwe, mem_wb_rd, id_ex_src2))
        ex_b = mem_wb_data;
    end
    case (id_ex_alu_sel)
      2'b00:   ex_alu = ex_a + ex_b;
      2'b01:   ex_alu = ex_a - ex_b;
      2'b10:   ex_alu = ex_a & ex_b;
      default: ex_alu = ex_a | ex_b;
    endcase
  end

  // PC, valid bits and retire counter; a hazard holds PC/IF-ID and bubbles ID/EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      if_id_valid  <= 1'b0;
      id_ex_valid  <= 1'b0;
      ex_mem_valid <= 1'b0;
      mem_wb_valid <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      if (!hazard) begin
        pc          <= pc + PC_W'(1);
        if_id_valid <= 1'b1;
      end
      id_ex_valid  <= if_id_valid && !hazard;
      ex_mem_valid <= id_ex_valid;
      mem_wb_valid <= ex_mem_valid;
      if (mem_wb_valid) retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

  // Register file: cleared by reset, written from WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regfile[i] <= '0;
    end else if (wb_write) begin
      regfile[mem_wb_rd] <= mem_wb_data;
    end
  end

  // Stage payloads; only meaningful when the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!hazard) if_id_instr <= imem_rdata;

    id_ex_rwe     <= reg_write_en;
    id_ex_mwe     <= mem_write_en;
    id_ex_mtr     <= mem_to_reg;
    id_ex_alu_sel <= alu_sel;
    id_ex_rd      <= id_rd;
    id_ex_src1    <= id_src1;
    id_ex_src2    <= id_rs2;
    id_ex_op1     <= id_rdata1;
    id_ex_op2     <= id_rdata2;
    id_ex_addr    <= if_id_instr[7:0];

    ex_mem_rwe    <= id_ex_rwe;
    ex_mem_mwe    <= id_ex_mwe;
    ex_mem_mtr    <= id_ex_mtr;
    ex_mem_rd     <= id_ex_rd;
    ex_mem_alu    <= ex_alu;
    ex_mem_sdata  <= ex_a;
    ex_mem_addr   <= id_ex_addr;

    mem_wb_rwe    <= ex_mem_rwe;
    mem_wb_rd     <= ex_mem_rd;
    mem_wb_data   <= ex_mem_mtr ? dmem_rdata : ex_mem_alu;
  end

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath: one forwarding instance (u_fwd) and one
// FWD_EN=0 instance (u_nofwd) share instruction memory and reset; each has its
// own data memory. Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 8 LD, 9 ST.
module tb_pipe_datapath;

  logic        clk;
  logic        rst;
  logic [15:0] imem [256];

  logic [7:0]  imem_addr0, imem_addr1;
  logic [15:0] imem_rdata0, imem_rdata1;
  logic [3:0]  opcode0, opcode1;
  logic [1:0]  alu_sel0, alu_sel1;
  logic        rwe0, rwe1, mwe0, mwe1, mtr0, mtr1, mop0, mop1;
  logic [7:0]  dmem_addr0, dmem_addr1;
  logic [7:0]  dmem_wdata0, dmem_wdata1;
  logic        dmem_we0, dmem_we1;
  logic [7:0]  dmem_rdata0, dmem_rdata1;
  logic        stall0, stall1;
  logic [15:0] retire0, retire1;

  logic [7:0]  dmem0 [256];
  logic [7:0]  dmem1 [256];
  int          we_cnt0, we_cnt1, st_cnt0, st_cnt1;
  int          base_we0, base_we1, base_st0, base_st1;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External control unit: {alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op}
  function automatic logic [5:0] decode(input logic [3:0] op);
    case (op)
      4'h1:    return 6'b00_1_0_0_0;
      4'h2:    return 6'b01_1_0_0_0;
      4'h3:    return 6'b10_1_0_0_0;
      4'h4:    return 6'b11_1_0_0_0;
      4'h8:    return 6'b00_1_0_1_1;
      4'h9:    return 6'b00_0_1_0_1;
      default: return 6'b00_0_0_0_0;
    endcase
  endfunction

  assign imem_rdata0 = imem[imem_addr0];
  assign imem_rdata1 = imem[imem_addr1];
  assign {alu_sel0, rwe0, mwe0, mtr0, mop0} = decode(opcode0);
  assign {alu_sel1, rwe1, mwe1, mtr1, mop1} = decode(opcode1);
  assign dmem_rdata0 = dmem0[dmem_addr0];
  assign dmem_rdata1 = dmem1[dmem_addr1];

  pipe_datapath #(.DATA_W(8), .PC_W(8), .FWD_EN(1), .RETIRE_W(16)) u_fwd (
    .clk(clk), .rst(rst), .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
    .opcode(opcode0), .alu_sel(alu_sel0), .reg_write_en(rwe0), .mem_write_en(mwe0),
    .mem_to_reg(mtr0), .mem_op(mop0), .dmem_addr(dmem_addr0), .dmem_wdata(dmem_wdata0),
    .dmem_we(dmem_we0), .dmem_rdata(dmem_rdata0), .stall(stall0), .retire_cnt(retire0)
  );

  pipe_datapath #(.DATA_W(8), .PC_W(8), .FWD_EN(0), .RETIRE_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .opcode(opcode1), .alu_sel(alu_sel1), .reg_write_en(rwe1), .mem_write_en(mwe1),
    .mem_to_reg(mtr1), .mem_op(mop1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
    .dmem_we(dmem_we1), .dmem_rdata(dmem_rdata1), .stall(stall1), .retire_cnt(retire1)
  );

  // Data memories, write-strobe and stall-cycle counters.
  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem0[i] = 8'h00;
      dmem1[i] = 8'h00;
    end
    dmem0[8'h00] = 8'h05; dmem1[8'h00] = 8'h05;
    dmem0[8'h01] = 8'h03; dmem1[8'h01] = 8'h03;
    dmem0[8'h02] = 8'hFF; dmem1[8'h02] = 8'hFF;
    dmem0[8'h03] = 8'h02; dmem1[8'h03] = 8'h02;
    dmem0[8'h10] = 8'h7F; dmem1[8'h10] = 8'h7F;
    we_cnt0 = 0; we_cnt1 = 0; st_cnt0 = 0; st_cnt1 = 0;
    forever begin
      @(posedge clk);
      if (dmem_we0) begin
        dmem0[dmem_addr0] <= dmem_wdata0;
        we_cnt0 <= we_cnt0 + 1;
      end
      if (dmem_we1) begin
        dmem1[dmem_addr1] <= dmem_wdata1;
        we_cnt1 <= we_cnt1 + 1;
      end
      if (stall0) st_cnt0 <= st_cnt0 + 1;
      if (stall1) st_cnt1 <= st_cnt1 + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic snap();
    base_we0 = we_cnt0; base_we1 = we_cnt1;
    base_st0 = st_cnt0; base_st1 = st_cnt1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;

    // Program 1: ALU chain with EX/MEM and MEM/WB forwarding, stores read back
    clear_imem();
    imem[0]  = 16'h8100;  // LD  r1,0x00   r1=5
    imem[1]  = 16'h8201;  // LD  r2,0x01   r2=3
    imem[2]  = 16'h0000;  // NOP
    imem[3]  = 16'h1312;  // ADD r3,r1,r2  =8
    imem[4]  = 16'h2431;  // SUB r4,r3,r1  =3
    imem[5]  = 16'h9430;  // ST  r4,0x30
    imem[6]  = 16'h1712;  // ADD r7,r1,r2  =8
    imem[7]  = 16'h9720;  // ST  r7,0x20
    imem[8]  = 16'h3812;  // AND r8,r1,r2  =1
    imem[9]  = 16'h4912;  // OR  r9,r1,r2  =7
    imem[10] = 16'h9821;  // ST  r8,0x21
    imem[11] = 16'h9922;  // ST  r9,0x22
    repeat (3) tick();

    // Run until the first store is in MEM, then reset over it
    rst = 1'b0;
    repeat (8) tick();
    check("st_r4_in_mem", 32'(dmem_we0), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_we_comb", 32'(dmem_we0), 32'h0);
    check("rst_stall_comb", 32'(stall0), 32'h0);
    snap();
    repeat (3) tick();
    check("rst_pc", 32'(imem_addr0), 32'h0);
    check("rst_retire", 32'(retire0), 32'h0);
    check("rst_we", 32'(dmem_we0), 32'h0);
    check("rst_stall", 32'(stall0), 32'h0);
    check("rst_no_write", 32'(we_cnt0 - base_we0), 32'h0);
    check("rst_mem30_kept", 32'(dmem0[8'h30]), 32'h00);

    // Program 1 from a clean reset
    snap();
    rst = 1'b0;
    tick();
    check("p1_pc_cycle1", 32'(imem_addr0), 32'h1);
    check("p1_opcode_ld", 32'(opcode0), 32'h8);
    repeat (23) tick();
    check("p1_pc", 32'(imem_addr0), 32'd24);
    check("p1_retire", 32'(retire0), 32'd20);
    check("p1_no_stall", 32'(st_cnt0 - base_st0), 32'h0);
    check("p1_we_pulses", 32'(we_cnt0 - base_we0), 32'd4);
    check("p1_sub", 32'(dmem0[8'h30]), 32'h03);
    check("p1_st_fwd_add", 32'(dmem0[8'h20]), 32'h08);
    check("p1_and", 32'(dmem0[8'h21]), 32'h01);
    check("p1_or", 32'(dmem0[8'h22]), 32'h07);
    repeat (56) tick();
    check("p1_nofwd_sub", 32'(dmem1[8'h30]), 32'h03);
    check("p1_nofwd_add", 32'(dmem1[8'h20]), 32'h08);
    check("p1_nofwd_and", 32'(dmem1[8'h21]), 32'h01);
    check("p1_nofwd_or", 32'(dmem1[8'h22]), 32'h07);
    check("p1_nofwd_we", 32'(we_cnt1 - base_we1), 32'd4);

    // Program 2: load-use stall and arithmetic wrap
    rst = 1'b1;
    clear_imem();
    imem[0] = 16'h8510;  // LD  r5,0x10   r5=7F
    imem[1] = 16'h1655;  // ADD r6,r5,r5  =FE (one stall)
    imem[2] = 16'h9631;  // ST  r6,0x31
    imem[3] = 16'h8102;  // LD  r1,0x02   r1=FF
    imem[4] = 16'h8203;  // LD  r2,0x03   r2=02
    imem[5] = 16'h0000;  // NOP
    imem[6] = 16'h1312;  // ADD r3,r1,r2  =01
    imem[7] = 16'h9340;  // ST  r3,0x40
    imem[8] = 16'h2A21;  // SUB r10,r2,r1 =03
    imem[9] = 16'h9A41;  // ST  r10,0x41
    repeat (2) tick();
    snap();
    rst = 1'b0;
    repeat (24) tick();
    check("p2_stalls", 32'(st_cnt0 - base_st0), 32'd1);
    check("p2_pc", 32'(imem_addr0), 32'd23);
    check("p2_retire", 32'(retire0), 32'd19);
    check("p2_we_pulses", 32'(we_cnt0 - base_we0), 32'd3);
    check("p2_load_use", 32'(dmem0[8'h31]), 32'hFE);
    check("p2_add_wrap", 32'(dmem0[8'h40]), 32'h01);
    check("p2_sub_wrap", 32'(dmem0[8'h41]), 32'h03);
    repeat (40) tick();
    check("p2_nofwd_load_use", 32'(dmem1[8'h31]), 32'hFE);
    check("p2_nofwd_add_wrap", 32'(dmem1[8'h40]), 32'h01);
    check("p2_nofwd_sub_wrap", 32'(dmem1[8'h41]), 32'h03);

    // Program 3: dependent ADD pair, compare forwarding against stalling
    rst = 1'b1;
    clear_imem();
    imem[0]  = 16'h8100;  // LD  r1,0x00
    imem[1]  = 16'h8201;  // LD  r2,0x01
    imem[5]  = 16'h1312;  // ADD r3,r1,r2  =8
    imem[6]  = 16'h1433;  // ADD r4,r3,r3  =10
    imem[10] = 16'h9430;  // ST  r4,0x30
    repeat (2) tick();
    snap();
    rst = 1'b0;
    repeat (30) tick();
    check("p3_fwd_stalls", 32'(st_cnt0 - base_st0), 32'd0);
    check("p3_nofwd_stalls", 32'(st_cnt1 - base_st1), 32'd3);
    check("p3_fwd_result", 32'(dmem0[8'h30]), 32'h10);
    check("p3_nofwd_result", 32'(dmem1[8'h30]), 32'h10);
    check("p3_fwd_retire", 32'(retire0), 32'd26);
    check("p3_nofwd_retire", 32'(retire1), 32'd23);

    // Program 4: NOP stream for PC and retire counter wrap
    rst = 1'b1;
    clear_imem();
    repeat (2) tick();
    rst = 1'b0;
    repeat (255) tick();
    check("pc_at_ff", 32'(imem_addr0), 32'hFF);
    tick();
    check("pc_wrap", 32'(imem_addr0), 32'h00);
    repeat (65283) tick();
    check("retire_at_ffff", 32'(retire0), 32'hFFFF);
    check("retire_nofwd_at_ffff", 32'(retire1), 32'hFFFF);
    tick();
    check("retire_wrap", 32'(retire0), 32'h0);
    check("retire_nofwd_wrap", 32'(retire1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
